// File: rtl/controller.sv
// controller: top-level sequencing FSM for the image-reordering accelerator
module controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             image_buffer_valid,
  input  logic [CNT_W-1:0] num_images,
  input  logic             hash_calc_done,
  input  logic             send_next_image,
  input  logic             finish_reordering,
  output logic             hash_start,
  output logic             reorder_start
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_IMAGE = 2'd1, WAIT_HASH = 2'd2, REORDER = 2'd3} state_t;
  state_t current_state, next_state;
  logic [CNT_W-1:0] img_cnt, img_cnt_next, total, total_next, cnt_inc;
  logic hash_start_next, reorder_start_next;
  logic unused_send_next_image;
  assign unused_send_next_image = send_next_image;
  assign cnt_inc = img_cnt + CNT_W'(1);
  // Registered state, counters and output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      current_state <= IDLE;
      img_cnt       <= '0;
      total         <= '0;
      hash_start    <= 1'b0;
      reorder_start <= 1'b0;
    end else begin
      current_state <= next_state;
      img_cnt       <= img_cnt_next;
      total         <= total_next;
      hash_start    <= hash_start_next;
      reorder_start <= reorder_start_next;
    end
  end
  // Next-state logic: only the input relevant to the current state is looked at
  always_comb begin
    next_state         = current_state;
    img_cnt_next       = img_cnt;
    total_next         = total;
    hash_start_next    = 1'b0;
    reorder_start_next = 1'b0;
    unique case (current_state)
      IDLE: if (start && num_images != '0) begin
        next_state   = WAIT_IMAGE;
        total_next   = num_images;
        img_cnt_next = '0;
      end
      WAIT_IMAGE: if (image_buffer_valid) begin
        next_state      = WAIT_HASH;
        hash_start_next = 1'b1;
      end
      WAIT_HASH: if (hash_calc_done) begin
        img_cnt_next       = cnt_inc;
        next_state         = (cnt_inc == total) ? REORDER : WAIT_IMAGE;
        reorder_start_next = (cnt_inc == total);
      end
      REORDER: if (finish_reordering) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_controller.sv
// tb_controller: scoreboard bench for the sequencing controller
module tb_controller;
  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, image_buffer_valid = 1'b0;
  logic hash_calc_done = 1'b0, send_next_image = 1'b0, finish_reordering = 1'b0;
  logic [15:0] num_images = '0;
  logic hash_start, reorder_start;

  typedef struct {
    logic [1:0]  state;
    logic        hs;
    logic        rs;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int hs_seen = 0, rs_seen = 0;
  logic [1:0]  m_state = 2'd0;
  logic [15:0] m_cnt = '0, m_total = '0;

  controller #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .image_buffer_valid(image_buffer_valid),
    .num_images(num_images), .hash_calc_done(hash_calc_done), .send_next_image(send_next_image),
    .finish_reordering(finish_reordering), .hash_start(hash_start), .reorder_start(reorder_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, predict the registered result, compare after the edge
  task automatic step(input logic r, input logic s, input logic v, input logic [15:0] n,
                      input logic h, input logic f);
    exp_t e, o;
    reset = r; start = s; image_buffer_valid = v; num_images = n;
    hash_calc_done = h; finish_reordering = f; send_next_image = 1'($urandom_range(0, 1));
    e.hs = 1'b0;
    e.rs = 1'b0;
    if (r) begin
      m_state = 2'd0; m_cnt = '0; m_total = '0;
    end else if (m_state == 2'd0) begin
      if (s && n != 16'd0) begin m_total = n; m_cnt = '0; m_state = 2'd1; end
    end else if (m_state == 2'd1) begin
      if (v) begin m_state = 2'd2; e.hs = 1'b1; end
    end else if (m_state == 2'd2) begin
      if (h) begin
        m_cnt = m_cnt + 16'd1;
        if (m_cnt == m_total) begin m_state = 2'd3; e.rs = 1'b1; end
        else m_state = 2'd1;
      end
    end else if (f) m_state = 2'd0;
    e.state = m_state;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check("state", 32'(dut.current_state), 32'(o.state));
    check("hash_start", 32'(hash_start), 32'(o.hs));
    check("reorder_start", 32'(reorder_start), 32'(o.rs));
    check("img_cnt", 32'(dut.img_cnt), 32'(o.cnt));
    hs_seen += int'(hash_start);
    rs_seen += int'(reorder_start);
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // three-image job
    hs_seen = 0; rs_seen = 0;
    step(0, 1, 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 3, 0, 0);
      step(0, 0, 0, 3, 1, 0);
    end
    step(0, 0, 0, 3, 0, 0);
    step(0, 0, 0, 3, 0, 1);
    check("job3_hash_pulses", hs_seen, 3);
    check("job3_reorder_pulses", rs_seen, 1);
    // single-image job
    hs_seen = 0; rs_seen = 0;
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1);
    check("job1_hash_pulses", hs_seen, 1);
    check("job1_reorder_pulses", rs_seen, 1);
    // ignored inputs, num_images changed mid-job, held image_buffer_valid
    step(0, 1, 0, 2, 0, 0);
    step(0, 0, 0, 7, 1, 0);
    step(0, 0, 0, 7, 0, 1);
    step(0, 1, 0, 7, 0, 0);
    step(0, 0, 1, 7, 0, 0);
    step(0, 1, 1, 7, 0, 1);
    step(0, 0, 1, 7, 1, 0);
    step(0, 0, 1, 7, 0, 0);
    step(0, 1, 0, 7, 1, 0);
    step(0, 1, 1, 7, 1, 0);
    step(0, 0, 0, 7, 0, 1);
    // zero-length job is ignored
    hs_seen = 0; rs_seen = 0;
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 1);
    check("zero_job_pulses", hs_seen + rs_seen, 0);
    // reset mid-job, then a fresh two-image job
    step(0, 1, 0, 3, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 3, 1, 0);
    step(0, 0, 1, 3, 0, 0);
    step(1, 0, 0, 3, 1, 0);
    hs_seen = 0; rs_seen = 0;
    step(0, 1, 0, 2, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 2, 0, 0);
      step(0, 0, 0, 2, 1, 0);
    end
    step(0, 0, 0, 2, 0, 1);
    check("job2_hash_pulses", hs_seen, 2);
    check("job2_reorder_pulses", rs_seen, 1);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
